// File: rtl/layer_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_mixer_pkg
// Purpose  : Shared RGB332 pixel definitions and layer index map for the compositor.
// Revision : 1.0
// ============================================================================
package layer_mixer_pkg;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int PIX_W = R_W + G_W + B_W;

    localparam int R_LSB = G_W + B_W;
    localparam int G_LSB = B_W;
    localparam int B_LSB = 0;

    localparam logic [PIX_W-1:0] COLOR_BLACK = 8'h00;
    localparam logic [PIX_W-1:0] COLOR_WHITE = 8'hFF;

    localparam int MAX_LAYERS = 16;

    localparam int LAYER_BALL = 0;
    localparam int LAYER_LPAD = 1;
    localparam int LAYER_RPAD = 2;
    localparam int LAYER_NET  = 3;

    // Index width that stays at least one bit for a single-layer build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : layer_mixer_pkg
`default_nettype wire

// File: rtl/layer_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : layer_priority_enc
// Purpose  : Combinational lowest-set-bit encoder with an any-valid flag.
// Revision : 1.0
// ============================================================================
module layer_priority_enc
    import layer_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = idx_width(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] vec,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scanning downwards leaves the lowest set index as the final winner.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : layer_priority_enc
`default_nettype wire

// File: rtl/layer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : layer_mixer
// Purpose  : Priority pixel compositor with per-frame layer collision flags.
// Revision : 1.0
// ============================================================================
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int                    NUM_LAYERS = 4,
    parameter logic [NUM_LAYERS-1:0] COLL_MASK  = {NUM_LAYERS{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic [PIX_W*NUM_LAYERS-1:0]   layer_color,
    input  logic [PIX_W-1:0]              bg_color,
    input  logic                          blank,
    input  logic                          vblank,
    output logic [R_W-1:0]                red,
    output logic [G_W-1:0]                green,
    output logic [B_W-1:0]                blue,
    output logic [NUM_LAYERS-1:0]         coll_flags,
    output logic                          coll_any,
    output logic                          frame_done
);

    localparam int c_idx_w = idx_width(NUM_LAYERS);

    logic [c_idx_w-1:0]    w_win;
    logic                  w_any;
    logic [PIX_W-1:0]      w_sel_color;
    logic [NUM_LAYERS-1:0] w_mask;
    logic [NUM_LAYERS-1:0] w_hit;
    logic                  w_edge;

    logic [PIX_W-1:0]      r_sel_color;
    logic                  r_blank_q;
    logic [PIX_W-1:0]      r_pix;
    logic [NUM_LAYERS-1:0] r_acc;
    logic [NUM_LAYERS-1:0] r_coll_flags;
    logic                  r_coll_any;
    logic                  r_frame_done;
    logic                  r_vblank_q;

    layer_priority_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (c_idx_w)
    ) u_prio (
        .vec (layer_valid),
        .idx (w_win),
        .any (w_any)
    );

    // Compare against constant indices so no variable-width array index is built.
    always_comb begin
        w_sel_color = bg_color;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (w_any && (w_win == c_idx_w'(i))) begin
                w_sel_color = layer_color[PIX_W*i +: PIX_W];
            end
        end
    end

    assign w_mask = layer_valid & COLL_MASK;

    generate
        for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_hit
            localparam logic [NUM_LAYERS-1:0] c_others = ~(NUM_LAYERS'(1) << i);
            assign w_hit[i] = w_mask[i] & (|(w_mask & c_others));
        end
    endgenerate

    assign w_edge = vblank & ~r_vblank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_color <= COLOR_BLACK;
            r_blank_q   <= 1'b0;
            r_pix       <= COLOR_BLACK;
        end else begin
            r_sel_color <= w_sel_color;
            r_blank_q   <= blank;
            r_pix       <= r_blank_q ? COLOR_BLACK : r_sel_color;
        end
    end

    // Vblank history resets high so a reset released inside vblank is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblank_q   <= 1'b1;
            r_acc        <= '0;
            r_coll_flags <= '0;
            r_coll_any   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vblank_q   <= vblank;
            r_frame_done <= w_edge;
            if (w_edge) begin
                r_coll_flags <= r_acc;
                r_coll_any   <= |r_acc;
                r_acc        <= '0;
            end else if (!blank) begin
                r_acc <= r_acc | w_hit;
            end
        end
    end

    assign red        = r_pix[R_LSB +: R_W];
    assign green      = r_pix[G_LSB +: G_W];
    assign blue       = r_pix[B_LSB +: B_W];
    assign coll_flags = r_coll_flags;
    assign coll_any   = r_coll_any;
    assign frame_done = r_frame_done;

endmodule : layer_mixer
`default_nettype wire

// File: tb/tb_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_mixer
// Purpose  : Randomised and directed self-checking bench for layer_mixer.
// Revision : 1.0
// ============================================================================
module tb_layer_mixer;

    localparam logic [3:0] COLL_MASK = 4'b0111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  layer_valid = '0;
    logic [31:0] layer_color = '0;
    logic [7:0]  bg_color = '0;
    logic        blank = 1'b1;
    logic        vblank = 1'b1;

    logic [2:0]  red, green, red1, green1;
    logic [1:0]  blue, blue1;
    logic [3:0]  coll_flags;
    logic [0:0]  coll_flags1;
    logic        coll_any, frame_done, coll_any1, frame_done1;

    int n_cmp = 0;
    int n_bad = 0;

    layer_mixer #(.NUM_LAYERS(4), .COLL_MASK(COLL_MASK)) dut (
        .clk(clk), .rst(rst), .layer_valid(layer_valid), .layer_color(layer_color),
        .bg_color(bg_color), .blank(blank), .vblank(vblank),
        .red(red), .green(green), .blue(blue),
        .coll_flags(coll_flags), .coll_any(coll_any), .frame_done(frame_done)
    );

    layer_mixer #(.NUM_LAYERS(1), .COLL_MASK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .layer_valid(layer_valid[0:0]), .layer_color(layer_color[7:0]),
        .bg_color(bg_color), .blank(blank), .vblank(vblank),
        .red(red1), .green(green1), .blue(blue1),
        .coll_flags(coll_flags1), .coll_any(coll_any1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    // Reference state: pixel history (newest first) and frame collision bookkeeping.
    logic [7:0] hist[$];
    logic [7:0] hist1[$];
    logic [3:0] m_acc, m_flags;
    logic       m_any, m_done, m_prev_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_pixel(input logic [3:0] v, input logic [31:0] c,
                                             input logic [7:0] bg, input logic bl);
        if (bl) return 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return c[8*i +: 8];
        end
        return bg;
    endfunction

    // A masked layer collides whenever at least two masked layers are present.
    function automatic logic [3:0] ref_hits(input logic [3:0] v);
        logic [3:0] m;
        int n;
        m = v & COLL_MASK;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m[i]);
        return (n >= 2) ? m : 4'b0000;
    endfunction

    task automatic model_reset();
        hist = '{8'h00, 8'h00};
        hist1 = '{8'h00, 8'h00};
        m_acc = '0; m_flags = '0; m_any = 1'b0; m_done = 1'b0; m_prev_v = 1'b1;
    endtask

    task automatic model_apply();
        hist.push_front(ref_pixel(layer_valid, layer_color, bg_color, blank));
        void'(hist.pop_back());
        hist1.push_front(ref_pixel({3'b000, layer_valid[0]}, {24'h0, layer_color[7:0]},
                                   bg_color, blank));
        void'(hist1.pop_back());
        if (vblank && !m_prev_v) begin
            m_flags = m_acc;
            m_any   = |m_acc;
            m_done  = 1'b1;
            m_acc   = '0;
        end else begin
            m_done = 1'b0;
            if (!blank) m_acc |= ref_hits(layer_valid);
        end
        m_prev_v = vblank;
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] col, input logic [7:0] bg,
                        input logic bl, input logic vb);
        @(negedge clk);
        check("rgb", {24'h0, red, green, blue}, {24'h0, hist[1]});
        check("coll_flags", {28'h0, coll_flags}, {28'h0, m_flags});
        check("coll_any", {31'h0, coll_any}, {31'h0, m_any});
        check("frame_done", {31'h0, frame_done}, {31'h0, m_done});
        check("rgb_n1", {24'h0, red1, green1, blue1}, {24'h0, hist1[1]});
        check("flags_n1", {31'h0, coll_flags1, coll_any1}, 32'h0);
        check("done_n1", {31'h0, frame_done1}, {31'h0, m_done});
        layer_valid = v; layer_color = col; bg_color = bg; blank = bl; vblank = vb;
        model_apply();
    endtask

    task automatic do_reset(input logic vb);
        @(negedge clk);
        rst = 1'b1;
        layer_valid = '0; blank = 1'b1; vblank = vb;
        #1;
        check("rst_rgb", {24'h0, red, green, blue}, 32'h0);
        check("rst_flags", {27'h0, coll_flags, coll_any}, 32'h0);
        check("rst_done", {30'h0, frame_done, frame_done1}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_apply();
    endtask

    task automatic frame_edge(input string tag, input logic [3:0] exp_flags);
        step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b1);
        step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b1);
        check({tag, "_flags"}, {28'h0, coll_flags}, {28'h0, exp_flags});
        check({tag, "_any"}, {31'h0, coll_any}, {31'h0, |exp_flags});
        check({tag, "_pulse"}, {31'h0, frame_done}, 32'h1);
        step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);
        check({tag, "_pulse_end"}, {31'h0, frame_done}, 32'h0);
    endtask

    logic [31:0] rc;

    initial begin
        model_reset();
        do_reset(1'b1);
        repeat (3) step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b1);
        repeat (2) step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);

        // Single layer, then background.
        step(4'b0100, 32'h00E0_0000, 8'h03, 1'b0, 1'b0);
        step(4'b0000, 32'h0, 8'h03, 1'b0, 1'b0);
        step(4'b0000, 32'h0, 8'h03, 1'b0, 1'b0);
        check("tp_layer2", {24'h0, red, green, blue}, 32'hE0);
        step(4'b0000, 32'h0, 8'h03, 1'b0, 1'b0);
        check("tp_bg", {24'h0, red, green, blue}, 32'h03);

        // Layers 1 and 2 overlap: layer 1 wins, both flagged.
        repeat (3) step(4'b0110, 32'h55E0_1CAA, 8'h03, 1'b0, 1'b0);
        check("tp_prio_l1", {24'h0, red, green, blue}, 32'h1C);
        frame_edge("tp_0110", 4'b0110);

        // Layer 3 is drawn but ignored for collisions.
        repeat (4) step(4'b1001, 32'h1111_2292, 8'h00, 1'b0, 1'b0);
        check("tp_prio_l0", {24'h0, red, green, blue}, 32'h92);
        frame_edge("tp_unmasked", 4'b0000);

        // Overlap only inside blanking.
        repeat (3) step(4'b0011, 32'hFFFF_FFFF, 8'h44, 1'b1, 1'b0);
        check("tp_blank_rgb", {24'h0, red, green, blue}, 32'h00);
        frame_edge("tp_blank", 4'b0000);

        // All layers at once, then a clean frame.
        repeat (3) step(4'b1111, 32'h0102_0304, 8'h00, 1'b0, 1'b0);
        check("tp_all_rgb", {24'h0, red, green, blue}, 32'h04);
        frame_edge("tp_all", 4'b0111);
        repeat (3) step(4'b0011, 32'h0000_C0C0, 8'h00, 1'b0, 1'b0);
        frame_edge("tp_frameN", 4'b0011);
        repeat (3) step(4'b0001, 32'h0000_00C0, 8'h00, 1'b0, 1'b0);
        frame_edge("tp_frameN1", 4'b0000);

        // Hit then reset mid-frame.
        repeat (2) step(4'b0011, 32'h0000_C0C0, 8'h00, 1'b0, 1'b0);
        do_reset(1'b0);
        repeat (3) step(4'b0001, 32'h0000_00C0, 8'h00, 1'b0, 1'b0);
        frame_edge("tp_after_rst", 4'b0000);

        // Toggling and long vblank.
        for (int i = 0; i < 8; i++) step(4'b0011, 32'h0, 8'h00, 1'b1, 1'(i % 2 == 0));
        repeat (6) step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b1);
        step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);

        // Random frames with occasional mid-frame reset.
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(20, 60);
            for (int k = 0; k < n; k++) begin
                rc = $urandom;
                step(4'($urandom_range(0, 15) & $urandom_range(0, 15)), rc,
                     8'($urandom), $urandom_range(0, 7) == 0, 1'b0);
            end
            if ($urandom_range(0, 9) == 0) do_reset(1'b0);
            repeat ($urandom_range(1, 4)) begin
                rc = $urandom;
                step(4'($urandom_range(0, 15)), rc, 8'($urandom), 1'b1, 1'b1);
            end
            repeat (2) step(4'b0000, 32'h0, 8'h00, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_layer_mixer
`default_nettype wire
